// File: rtl/insn_queue_nway.sv
// N-in / M-out circular instruction queue between fetch and dispatch, with whole-queue squash.
// Optional same-cycle bypass into empty dispatch slots when INSN_QUEUE_BYPASS_EN is defined.
module insn_queue_nway #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 2,
    parameter int unsigned PKT_W = 96,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned DPC_W = $clog2(OUT_W + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash_in,
    input  logic [IN_W-1:0]          if_valid_in,
    input  logic [IN_W*PKT_W-1:0]    if_packet_in,
    output logic                     if_ready_out,
    input  logic [DPC_W-1:0]         dp_count_in,
    output logic [OUT_W-1:0]         dp_valid_out,
    output logic [OUT_W*PKT_W-1:0]   dp_packet_out,
    output logic [CNT_W-1:0]         count_out,
    output logic                     full_out
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned KCNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] ReadyMax = CNT_W'(DEPTH - IN_W);

    logic [PKT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [KCNT_W-1:0] push_cnt;
    logic [CNT_W-1:0]  push_amt, pop_cnt;
    logic [PTR_W-1:0]  wr_idx [IN_W];
    logic [PTR_W-1:0]  rd_idx;
    logic [IN_W-1:0]   valid_inc;

    // Group-atomic: accept only when a full IN_W group is guaranteed to fit.
    assign if_ready_out = (count_q <= ReadyMax);
    assign full_out     = (count_q == CNT_W'(DEPTH));
    assign count_out    = count_q;
    assign valid_inc    = if_valid_in + IN_W'(1);

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (if_valid_in[i]) begin
                push_cnt = push_cnt + KCNT_W'(1);
            end
        end
        push_amt = if_ready_out ? CNT_W'(push_cnt) : '0;
        pop_cnt  = (CNT_W'(dp_count_in) > count_q) ? count_q : CNT_W'(dp_count_in);
        for (int i = 0; i < IN_W; i++) begin
            wr_idx[i] = tail_q + PTR_W'(i);
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop_cnt);
        tail_d  = tail_q + PTR_W'(push_amt);
        count_d = count_q + push_amt - pop_cnt;
        if (squash_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            assert ((if_valid_in & valid_inc) == '0);
        end
    end

    // Storage is not reset; contents are only observed once counted as occupied.
    always_ff @(posedge clock) begin
        if (reset && !squash_in && if_ready_out) begin
            for (int i = 0; i < IN_W; i++) begin
                if (if_valid_in[i]) begin
                    mem_q[wr_idx[i]] <= if_packet_in[i*PKT_W +: PKT_W];
                end
            end
        end
    end

    always_comb begin
        dp_valid_out  = '0;
        dp_packet_out = '0;
        rd_idx        = '0;
        for (int j = 0; j < OUT_W; j++) begin
            rd_idx                         = head_q + PTR_W'(j);
            dp_valid_out[j]                = (count_q > CNT_W'(j));
            dp_packet_out[j*PKT_W +: PKT_W] = mem_q[rd_idx];
`ifdef INSN_QUEUE_BYPASS_EN
            // Slots beyond occupancy show incoming fetch slots directly.
            if (count_q < CNT_W'(OUT_W) && if_ready_out && CNT_W'(j) >= count_q) begin
                dp_valid_out[j] = 1'b0;
                for (int s = 0; s < IN_W; s++) begin
                    if ((count_q + CNT_W'(s)) == CNT_W'(j)) begin
                        dp_valid_out[j]                = if_valid_in[s] & ~squash_in;
                        dp_packet_out[j*PKT_W +: PKT_W] = if_packet_in[s*PKT_W +: PKT_W];
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_insn_queue_nway.sv
// Self-checking bench for insn_queue_nway: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_insn_queue_nway;

    localparam int DEPTH = 16;
    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int PKT_W = 96;
    localparam int CNT_W = 5;
    localparam int DPC_W = 2;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   squash_in = 1'b0;
    logic [IN_W-1:0]        if_valid_in = '0;
    logic [IN_W*PKT_W-1:0]  if_packet_in = '0;
    logic                   if_ready_out;
    logic [DPC_W-1:0]       dp_count_in = '0;
    logic [OUT_W-1:0]       dp_valid_out;
    logic [OUT_W*PKT_W-1:0] dp_packet_out;
    logic [CNT_W-1:0]       count_out;
    logic                   full_out;

    insn_queue_nway dut (
        .clock         (clock),
        .reset         (reset),
        .squash_in     (squash_in),
        .if_valid_in   (if_valid_in),
        .if_packet_in  (if_packet_in),
        .if_ready_out  (if_ready_out),
        .dp_count_in   (dp_count_in),
        .dp_valid_out  (dp_valid_out),
        .dp_packet_out (dp_packet_out),
        .count_out     (count_out),
        .full_out      (full_out)
    );

    always #5 clock = ~clock;

    logic [PKT_W-1:0] model_q[$];
    int errors = 0;
    int checks = 0;
    int tag = 0;

    task automatic check(input string name, input logic [PKT_W-1:0] got,
                         input logic [PKT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic [IN_W-1:0] v, input int dpc, input logic sq,
                         input logic rst, input bit do_check);
        logic [IN_W*PKT_W-1:0] pk;
        logic [OUT_W-1:0]      ev;
        logic [PKT_W-1:0]      ep [OUT_W];
        int                    sz;
        int                    p;
        bit                    ready_e;
        for (int i = 0; i < IN_W; i++) begin
            pk[i*PKT_W +: PKT_W] = {$urandom, $urandom, 32'(tag + i)};
        end
        if_valid_in  = v;
        if_packet_in = pk;
        dp_count_in  = DPC_W'(dpc);
        squash_in    = sq;
        reset        = rst;
        #2;
        sz      = model_q.size();
        ready_e = (DEPTH - sz) >= IN_W;
        if (do_check) begin
            check("count", PKT_W'(count_out), PKT_W'(sz));
            check("ready", PKT_W'(if_ready_out), PKT_W'(ready_e));
            check("full", PKT_W'(full_out), PKT_W'(sz == DEPTH));
            for (int j = 0; j < OUT_W; j++) begin
                ev[j] = (sz > j);
                ep[j] = (sz > j) ? model_q[j] : '0;
            end
`ifdef INSN_QUEUE_BYPASS_EN
            if (sz < OUT_W && ready_e) begin
                for (int j = sz; j < OUT_W; j++) begin
                    if (j - sz < IN_W) begin
                        ev[j] = v[j - sz] & ~sq;
                        ep[j] = pk[(j - sz)*PKT_W +: PKT_W];
                    end
                end
            end
`endif
            check("dp_valid", PKT_W'(dp_valid_out), PKT_W'(ev));
            for (int j = 0; j < OUT_W; j++) begin
                if (ev[j]) check("dp_packet", dp_packet_out[j*PKT_W +: PKT_W], ep[j]);
            end
        end
        @(posedge clock);
        if (!rst || sq) begin
            model_q.delete();
        end else begin
            p = (dpc < sz) ? dpc : sz;
            repeat (p) void'(model_q.pop_front());
            if (ready_e) begin
                for (int i = 0; i < IN_W; i++) begin
                    if (v[i]) begin
                        model_q.push_back(pk[i*PKT_W +: PKT_W]);
                        tag++;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [4:0] m;
        // Reset held two cycles with a full push group presented.
        cycle(4'b1111, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 0, 1'b0, 1'b1, 1'b1);

        // Fill to full; fifth group must be dropped.
        repeat (5) cycle(4'b1111, 0, 1'b0, 1'b1, 1'b1);
        cycle(4'b0000, 0, 1'b0, 1'b1, 1'b1);

        // Wrap: tags 0..11, pop 2 x5, then tags 12..15 wrap the tail.
        cycle(4'b0000, 0, 1'b1, 1'b1, 1'b1);
        tag = 0;
        repeat (3) cycle(4'b1111, 0, 1'b0, 1'b1, 1'b1);
        repeat (5) cycle(4'b0000, 2, 1'b0, 1'b1, 1'b1);
        cycle(4'b1111, 0, 1'b0, 1'b1, 1'b1);
        check("wrap_head_tag", PKT_W'(dp_packet_out[31:0]), PKT_W'(10));
        repeat (4) cycle(4'b0000, 2, 1'b0, 1'b1, 1'b1);

        // Simultaneous push and pop at count 6.
        cycle(4'b1111, 0, 1'b0, 1'b1, 1'b1);
        cycle(4'b0011, 0, 1'b0, 1'b1, 1'b1);
        cycle(4'b0011, 2, 1'b0, 1'b1, 1'b1);
        check("simul_count", PKT_W'(count_out), PKT_W'(6));

        // Squash at count 9 overrides same-cycle push and pop.
        cycle(4'b0000, 0, 1'b1, 1'b1, 1'b1);
        cycle(4'b1111, 0, 1'b0, 1'b1, 1'b1);
        cycle(4'b1111, 0, 1'b0, 1'b1, 1'b1);
        cycle(4'b0001, 0, 1'b0, 1'b1, 1'b1);
        cycle(4'b1111, 2, 1'b1, 1'b1, 1'b1);
        check("squash_count", PKT_W'(count_out), PKT_W'(0));
        cycle(4'b0001, 0, 1'b0, 1'b1, 1'b1);

        // Pop request larger than occupancy is clipped.
        cycle(4'b0000, 2, 1'b0, 1'b1, 1'b1);
        check("clip_count", PKT_W'(count_out), PKT_W'(0));
        cycle(4'b0000, 2, 1'b0, 1'b1, 1'b1);
        cycle(4'b0011, 0, 1'b0, 1'b1, 1'b1);

        // Random traffic with occasional squash and reset.
        for (int n = 0; n < 400; n++) begin
            m = (5'd1 << $urandom_range(0, IN_W)) - 5'd1;
            cycle(m[3:0], int'($urandom_range(0, OUT_W)), ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) >= 1), 1'b1);
        end
        cycle(4'b0000, 0, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
